int_to_float_conv: RTL and testbench
====================================

Name: int_to_float_conv

Overview:
- Parametrised, handshaked integer-to-floating-point converter for the FPU (FCVT.S.W / FCVT.S.WU path).
- Converts a signed or unsigned INT_W-bit integer to an IEEE-754 binary format of configurable exponent and mantissa width.
- Uses a fixed-latency multi-state pipeline with valid/ready on both sides and returns the inexact flag for fflags accumulation.

Parameters:
- INT_W, 32, integer operand width.
- EXP_W, 8, result exponent width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 23, result stored mantissa width, hidden bit excluded.
- Constraint: INT_W <= 2^(EXP_W-1)-1. Overflow is impossible under this constraint; violating it is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept an operand.
- in_a  in  INT_W  integer operand.
- in_signed  in  1  1: in_a is two's complement; 0: in_a is unsigned.
- in_rm  in  3  RISC-V rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_z  out  1+EXP_W+MAN_W  packed float {sign, exp, man}.
- out_nx  out  1  inexact flag for this result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, out_z=0, out_nx=0.
  - All internal registers are cleared.
  - Any in-flight conversion is discarded and no result is produced.
- FSM states: IDLE -> NORM -> ROUND -> PACK -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch in_a, in_signed, in_rm.
  - sign = in_signed & in_a[INT_W-1].
  - mag = sign ? -in_a : in_a, computed INT_W bits unsigned, so INT_MIN gives magnitude 2^(INT_W-1).
  - Go to NORM.
- NORM (single cycle):
  - Leading-zero count over mag; left-shift mag so its MSB is 1; e = INT_W-1-lzc.
  - If mag==0, set zero flag; the result is +0.0 regardless of in_rm.
- ROUND:
  - Take the top MAN_W+1 bits as significand; guard = next bit; sticky = OR of the remaining bits. Zero-extend when INT_W <= MAN_W+1, which gives guard=sticky=0.
  - Increment decision:
    - RNE: g & (s | lsb).
    - RTZ: never.
    - RDN: sign & (g|s).
    - RUP: ~sign & (g|s).
    - RMM: g.
  - in_rm 5..7 is treated as RNE.
  - A significand carry-out renormalises: significand = 1000..0, e+1.
  - nx = g|s.
- PACK: z = {sign, e+bias (EXP_W bits), significand[MAN_W-1:0]}. For zero, z is all zeros and nx=0.
- DONE:
  - out_valid=1; out_z and out_nx are registered and held stable while out_ready=0. in_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: accept edge to out_valid=1 is 4 cycles. Throughput is one conversion per 5 cycles minimum.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Rising edge of reset mid-operation: starts in IDLE with in_ready=1.

Optional Feature:
- INT2F_RM_EN defined: all rounding modes are supported as above.
- INT2F_RM_EN undefined: in_rm is ignored and round-to-nearest-even is always used. The rounding-mode mux is not synthesised; the in_rm port remains present.

Test Plan:
- Unsigned in_a=0xFFFFFFFF, RNE -> out_z=0x4F800000, out_nx=1, out_valid 4 cycles after accept.
- Signed in_a=0xFFFFFFFF -> 0xBF800000, nx=0. Signed in_a=0x80000000 -> 0xCF000000, nx=0. in_a=0 (either mode) -> 0x00000000, nx=0.
- Unsigned 0x01000001: RNE -> 0x4B800000 nx=1; RUP -> 0x4B800001; RTZ -> 0x4B800000. Signed 0xFEFFFFFF with RDN -> 0xCB800001 nx=1 (RUP -> 0xCB800000).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_z/out_nx stable, in_ready=0, and a new in_valid is not accepted. Release -> handshake, IDLE next cycle.
- Assert rst=0 during ROUND -> outputs take reset values immediately, no result emitted. Next operand 0x00000003 unsigned -> 0x40400000.
- INT_W=16, EXP_W=8, MAN_W=23 build: signed 0x8000 -> 0xC7000000 exact. Compile without INT2F_RM_EN with in_rm=3 on 0x01000001 -> 0x4B800000.

Source files
------------

// File: rtl/int_to_float_conv.sv
// rtl/int_to_float_conv.sv - handshaked integer to IEEE-754 float converter (FCVT.S.W / FCVT.S.WU)
// Optional feature macro: INT2F_RM_EN (all RISC-V rounding modes); undefined -> round-to-nearest-even only.

module int_to_float_conv #(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       in_a,
    input  logic                   in_signed,
    input  logic [2:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic                   out_nx
);

    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int LZ_W  = $clog2(INT_W + 1);
    localparam int EXT_W = INT_W + MAN_W + 3;

    // The integer must fit below the bias so the biased exponent can never overflow
    generate
        if (INT_W > BIAS) begin : g_bad_int_w
            $error("int_to_float_conv: INT_W must not exceed 2^(EXP_W-1)-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_ROUND = 3'd2,
        S_PACK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [INT_W-1:0]       mag_q, mag_d;
    logic                   sign_q, sign_d;
    logic                   zero_q, zero_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic [MAN_W-1:0]       sig_q, sig_d;
    logic                   nx_q, nx_d;
    logic [EXP_W+MAN_W:0]   z_q, z_d;
    logic                   out_nx_q, out_nx_d;
    logic                   out_valid_q, out_valid_d;

`ifdef INT2F_RM_EN
    logic [2:0]             rm_q, rm_d;
`else
    logic                   unused_rm;
    assign unused_rm = ^in_rm;
`endif

    logic [LZ_W-1:0]        lzc;
    logic [EXT_W-1:0]       ext;
    logic [MAN_W:0]         rnd_sig;
    logic                   guard;
    logic                   sticky;
    logic                   inc;
    logic [MAN_W+1:0]       sum;
    logic                   unused_hidden;

    // Leading-zero count of the latched magnitude (INT_W when the magnitude is zero)
    always_comb begin
        lzc = LZ_W'(INT_W);
        for (int i = 0; i < INT_W; i++) begin
            if (mag_q[i]) begin
                lzc = LZ_W'(INT_W - 1 - i);
            end
        end
    end

    // Split the normalised magnitude into significand, guard and sticky; the zero
    // padding below the magnitude makes narrow integers come out exact.
    always_comb begin
        ext     = {mag_q, {(MAN_W+3){1'b0}}};
        rnd_sig = ext[EXT_W-1 -: MAN_W+1];
        guard   = ext[EXT_W-MAN_W-2];
        sticky  = |ext[EXT_W-MAN_W-3:0];
    end

    // Round-up decision for the selected rounding mode
    always_comb begin
`ifdef INT2F_RM_EN
        case (rm_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sign_q & (guard | sticky);
            3'd3:    inc = ~sign_q & (guard | sticky);
            3'd4:    inc = guard;
            default: inc = guard & (sticky | rnd_sig[0]);
        endcase
`else
        inc = guard & (sticky | rnd_sig[0]);
`endif
        sum = {1'b0, rnd_sig} + {{(MAN_W+1){1'b0}}, inc};
    end

    // Hidden bit of the rounded significand is implied in the packed format
    assign unused_hidden = sum[MAN_W];

    // Next-state and datapath register updates for each pipeline step
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        exp_d       = exp_q;
        sig_d       = sig_q;
        nx_d        = nx_q;
        z_d         = z_q;
        out_nx_d    = out_nx_q;
        out_valid_d = out_valid_q;
`ifdef INT2F_RM_EN
        rm_d        = rm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_signed & in_a[INT_W-1];
                    mag_d   = (in_signed & in_a[INT_W-1]) ? (~in_a + 1'b1) : in_a;
`ifdef INT2F_RM_EN
                    rm_d    = in_rm;
`endif
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                zero_d  = (mag_q == '0);
                mag_d   = mag_q << lzc;
                exp_d   = EXP_W'(INT_W - 1) - EXP_W'(lzc);
                state_d = S_ROUND;
            end
            S_ROUND: begin
                sig_d = sum[MAN_W-1:0];
                if (sum[MAN_W+1]) begin
                    exp_d = exp_q + 1'b1;
                end
                nx_d    = guard | sticky;
                state_d = S_PACK;
            end
            S_PACK: begin
                if (zero_q) begin
                    z_d      = '0;
                    out_nx_d = 1'b0;
                end else begin
                    z_d      = {sign_q, exp_q + EXP_W'(BIAS), sig_q};
                    out_nx_d = nx_q;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            nx_q        <= 1'b0;
            z_q         <= '0;
            out_nx_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef INT2F_RM_EN
            rm_q        <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            nx_q        <= nx_d;
            z_q         <= z_d;
            out_nx_q    <= out_nx_d;
            out_valid_q <= out_valid_d;
`ifdef INT2F_RM_EN
            rm_q        <= rm_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_z     = z_q;
    assign out_nx    = out_nx_q;

endmodule

// File: tb/tb_int_to_float_conv.sv
// tb/tb_int_to_float_conv.sv - randomized self-checking bench for int_to_float_conv

module tb_int_to_float_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic        in_signed = 1'b0;
    logic [2:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic        out_nx;

    logic        v16_valid = 1'b0;
    logic        v16_ready;
    logic [15:0] v16_a = '0;
    logic        v16_signed = 1'b0;
    logic        v16_ovalid;
    logic [31:0] v16_z;
    logic        v16_nx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit busy = 1'b0;
    int acc_cyc = 0;
    logic [31:0] exp_z = '0;
    logic        exp_nx = 1'b0;

    int_to_float_conv #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_signed(in_signed), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_nx(out_nx)
    );

    int_to_float_conv #(.INT_W(16), .EXP_W(8), .MAN_W(23)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16_valid), .in_ready(v16_ready), .in_a(v16_a),
        .in_signed(v16_signed), .in_rm(3'd0),
        .out_valid(v16_ovalid), .out_ready(1'b1), .out_z(v16_z), .out_nx(v16_nx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference conversion from the numeric value: exact quotient/remainder rounding
    function automatic void model(input logic [31:0] a, input logic sgn, input logic [2:0] rm,
                                  output logic [31:0] z, output logic nx);
        longint mag, q, rem, half;
        bit neg, up;
        int e, sh, mode;
        neg = sgn && a[31];
        mag = longint'({32'b0, a});
        if (neg) mag = 64'h1_0000_0000 - mag;
        if (mag == 0) begin
            z = '0;
            nx = 1'b0;
            return;
        end
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        half = 1;
        rem = 0;
        if (e <= 23) begin
            q = mag << (23 - e);
        end else begin
            sh = e - 23;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = longint'(1) << (sh - 1);
        end
`ifdef INT2F_RM_EN
        mode = (rm > 3'd4) ? 0 : int'(rm);
`else
        mode = (rm == 3'd7) ? 0 : 0;
`endif
        case (mode)
            1: up = 1'b0;
            2: up = neg && (rem != 0);
            3: up = !neg && (rem != 0);
            4: up = (rem != 0) && (rem >= half);
            default: up = (rem > half) || ((rem != 0) && (rem == half) && q[0]);
        endcase
        if (up) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        z = {neg, 8'(e + 127), q[22:0]};
        nx = (rem != 0);
    endfunction

    // Cycle-level compare: handshake timing plus result value against the model
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            busy = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_z", 64'(out_z), 64'd0);
            chk("rst_out_nx", 64'(out_nx), 64'd0);
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!busy));
            chk("out_valid", 64'(out_valid), 64'(busy && (cyc >= acc_cyc + 4)));
            if (out_valid && busy) begin
                chk("out_z", 64'(out_z), 64'(exp_z));
                chk("out_nx", 64'(out_nx), 64'(exp_nx));
            end
            if (!busy && in_valid) begin
                model(in_a, in_signed, in_rm, exp_z, exp_nx);
                busy = 1'b1;
                acc_cyc = cyc;
            end else if (busy && out_valid && out_ready) begin
                busy = 1'b0;
            end
        end
    end

    task automatic conv(input logic [31:0] a, input logic s, input logic [2:0] rm,
                        input logic [31:0] ez, input logic enx, input string nm);
        int n;
        @(posedge clk); #1;
        in_a = a; in_signed = s; in_rm = rm; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) chk({nm, "_accept_timeout"}, 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        if (n == 10) chk({nm, "_result_timeout"}, 64'd1, 64'd0);
        chk({nm, "_z"}, 64'(out_z), 64'(ez));
        chk({nm, "_nx"}, 64'(out_nx), 64'(enx));
        @(posedge clk); #1;
    endtask

    task automatic conv16(input logic [15:0] a, input logic s, input logic [31:0] ez, input string nm);
        int n;
        @(posedge clk); #1;
        v16_a = a; v16_signed = s; v16_valid = 1'b1;
        n = 0;
        while (!v16_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        v16_valid = 1'b0;
        n = 0;
        while (!v16_ovalid && n < 10) begin @(posedge clk); #1; n++; end
        if (n == 10) chk({nm, "_timeout"}, 64'd1, 64'd0);
        chk({nm, "_z"}, 64'(v16_z), 64'(ez));
        chk({nm, "_nx"}, 64'(v16_nx), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] q;
        int sh;
        case ($urandom_range(0, 5))
            0: rand_a = $urandom;
            1: rand_a = 32'($urandom_range(0, 15));
            2: begin
                case ($urandom_range(0, 3))
                    0: rand_a = 32'h0000_0000;
                    1: rand_a = 32'hFFFF_FFFF;
                    2: rand_a = 32'h8000_0000;
                    default: rand_a = 32'h7FFF_FFFF;
                endcase
            end
            3: rand_a = $urandom >> $urandom_range(0, 31);
            4: begin
                q = 32'($urandom_range(0, 32'h00FF_FFFF)) | 32'h0080_0000;
                sh = $urandom_range(1, 8);
                rand_a = (q << sh) | (32'd1 << (sh - 1));
            end
            default: rand_a = ~($urandom >> $urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bz;
        logic        bnx;
        logic        wacc;
        int          n, k, guard_cyc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        conv(32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 1'b1, "u_ffffffff_rne");
        conv(32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0, "s_minus1");
        conv(32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 1'b0, "s_intmin");
        conv(32'h0000_0000, 1'b0, 3'd3, 32'h0000_0000, 1'b0, "u_zero");
        conv(32'h0000_0000, 1'b1, 3'd2, 32'h0000_0000, 1'b0, "s_zero");
        conv(32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, "u_tie_rne");
        conv(32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1, "u_tie_rtz");
`ifdef INT2F_RM_EN
        conv(32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1, "u_tie_rup");
        conv(32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0001, 1'b1, "s_tie_rdn");
        conv(32'hFEFF_FFFF, 1'b1, 3'd3, 32'hCB80_0000, 1'b1, "s_tie_rup");
`else
        conv(32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0000, 1'b1, "u_tie_rm_ignored");
        conv(32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0000, 1'b1, "s_tie_rm_ignored");
`endif

        // Backpressure: result held while out_ready is low, new operand ignored
        model(32'h1234_5679, 1'b0, 3'd0, bz, bnx);
        @(posedge clk); #1;
        in_a = 32'h1234_5679; in_signed = 1'b0; in_rm = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_a = 32'h0000_0005;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        if (n == 10) chk("bp_timeout", 64'd1, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_z", 64'(out_z), 64'(bz));
            chk("bp_out_nx", 64'(out_nx), 64'(bnx));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Reset asserted while the conversion is in ROUND
        @(posedge clk); #1;
        in_a = 32'h0000_FFFF; in_signed = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_z", 64'(out_z), 64'd0);
        chk("midrst_out_nx", 64'(out_nx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_result", 64'(out_valid), 64'd0);
        end
        conv(32'h0000_0003, 1'b0, 3'd0, 32'h4040_0000, 1'b0, "after_rst_3");

        conv16(16'h8000, 1'b1, 32'hC700_0000, "w16_s_min");
        conv16(16'hFFFF, 1'b0, 32'h477F_FF00, "w16_u_max");

        // Randomized traffic with random consumer backpressure
        k = 0;
        guard_cyc = 0;
        wacc = 1'b0;
        while (k < 300 && guard_cyc < 20000) begin
            @(posedge clk); #1;
            guard_cyc++;
            if (wacc) begin
                k++;
                in_valid = 1'b0;
            end
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_a = rand_a();
                in_signed = 1'($urandom_range(0, 1));
                in_rm = 3'($urandom_range(0, 7));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wacc = in_valid && in_ready;
        end
        if (k < 300) chk("random_progress", 64'(k), 64'd300);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_idle", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
